// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: serialises one 9-bit LCD word (D/C flag + byte) onto a mode-0 SPI link.
// Each accepted word runs LOAD, SHIFT (8 bits, MSB first), DONE and GAP, then returns to IDLE.
// Every pin is driven straight from a register, so the outputs carry no combinational glitches.
module lcd_spi_writer #(
    parameter int unsigned SCLK_HALF = 2  // sys_clk cycles per SCLK half-period, 1..15
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StDone,
        StGap
    } state_e;

    // Terminal count of the half-period divider.
    localparam logic [3:0] DivMax = 4'(SCLK_HALF - 1);

    state_e     state_q;
    logic [3:0] div_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [8:0] shift_q;

    // This block holds the sequencer, the counters, the shift register and all registered pins.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wr_done   <= 1'b0;
            busy      <= 1'b0;
            lcd_cs    <= 1'b1;
            lcd_dc    <= 1'b0;
            lcd_sclk  <= 1'b0;
            lcd_mosi  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_write) begin
                        // The word is captured here. Later changes on data or en_write do not
                        // reach it.
                        shift_q   <= data;
                        lcd_dc    <= data[8];
                        lcd_mosi  <= data[7];
                        lcd_cs    <= 1'b0;
                        lcd_sclk  <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= StShift;
                end
                StShift: begin
                    if (div_cnt_q == DivMax) begin
                        div_cnt_q <= '0;
                        if (!lcd_sclk) begin
                            // The low phase of the current bit has ended.
                            lcd_sclk <= 1'b1;
                        end else begin
                            // The high phase has ended. The clock falls here, so MOSI may change.
                            lcd_sclk <= 1'b0;
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q <= '0;
                                lcd_mosi  <= 1'b0;
                                lcd_cs    <= 1'b1;
                                wr_done   <= 1'b1;
                                state_q   <= StDone;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                // The byte rotates, so it is intact again after eight steps.
                                shift_q   <= {shift_q[8], shift_q[6:0], shift_q[7]};
                                lcd_mosi  <= shift_q[6];
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StGap;
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
